// File: rtl/fdma_rw_arbiter.sv
// fdma_rw_arbiter: shares one SDRAM FDMA master between the merged write stream and the
// display read stream. One burst in flight at a time; reads have priority, bounded by a
// streak counter so a pending write is served after MAX_RD_STREAK consecutive reads.
// New grants are held off while the SDRAM controller is busy, and a watchdog aborts a
// request that the FDMA never acknowledges.
module fdma_rw_arbiter #(
  parameter int unsigned ADDR_W        = 21,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_RD_STREAK = 4,
  parameter int unsigned REQ_TIMEOUT   = 1023
) (
  input  logic              I_fdma_clk,
  input  logic              I_fdma_rst,
  input  logic              I_sdr_busy,
  // upstream write stream
  input  logic [ADDR_W-1:0] I_w_addr,
  input  logic              I_w_areq,
  input  logic [15:0]       I_w_size,
  input  logic [DATA_W-1:0] I_w_data,
  output logic              O_w_busy,
  output logic              O_w_valid,
  // upstream read stream
  input  logic [ADDR_W-1:0] I_r_addr,
  input  logic              I_r_areq,
  input  logic [15:0]       I_r_size,
  output logic [DATA_W-1:0] O_r_data,
  output logic              O_r_busy,
  output logic              O_r_valid,
  // FDMA write port
  output logic [ADDR_W-1:0] O_fdma_waddr,
  output logic              O_fdma_wareq,
  output logic [15:0]       O_fdma_wsize,
  output logic [DATA_W-1:0] O_fdma_wdata,
  input  logic              I_fdma_wbusy,
  input  logic              I_fdma_wvalid,
  // FDMA read port
  output logic [ADDR_W-1:0] O_fdma_raddr,
  output logic              O_fdma_rareq,
  output logic [15:0]       O_fdma_rsize,
  input  logic [DATA_W-1:0] I_fdma_rdata,
  input  logic              I_fdma_rbusy,
  input  logic              I_fdma_rvalid,
  // watchdog abort pulse
  output logic              O_timeout
);

  localparam int unsigned StreakW = $clog2(MAX_RD_STREAK + 1);
  localparam int unsigned WdogW   = $clog2(REQ_TIMEOUT + 1);

  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_RD_STREAK);
  // Last watchdog value before abort: areq is then high for exactly REQ_TIMEOUT cycles.
  localparam logic [WdogW-1:0]   WdogLast  = WdogW'(REQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWReq,
    StWRun,
    StRReq,
    StRRun
  } state_e;

  state_e              state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wsize_q, wsize_d;
  logic                wareq_q, wareq_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [15:0]         rsize_q, rsize_d;
  logic                rareq_q, rareq_d;
  logic                timeout_q, timeout_d;

  logic                w_owned;
  logic                r_owned;
  logic                grant_r;
  logic                grant_w;

  // Read wins unless a write is waiting and reads have used up their streak.
  assign grant_r = I_r_areq && !(I_w_areq && (streak_q == StreakMax));
  assign grant_w = !grant_r && I_w_areq;

  // Next-state, grant latching and watchdog.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    wdog_d    = wdog_q;
    waddr_d   = waddr_q;
    wsize_d   = wsize_q;
    wareq_d   = wareq_q;
    raddr_d   = raddr_q;
    rsize_d   = rsize_q;
    rareq_d   = rareq_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // SDRAM refresh/init only blocks the decision; bursts already granted run on.
        if (!I_sdr_busy) begin
          if (grant_r) begin
            state_d = StRReq;
            raddr_d = I_r_addr;
            rsize_d = I_r_size;
            rareq_d = 1'b1;
            wdog_d  = '0;
            if (streak_q != StreakMax) begin
              streak_d = streak_q + 1'b1;
            end
          end else if (grant_w) begin
            state_d  = StWReq;
            waddr_d  = I_w_addr;
            wsize_d  = I_w_size;
            wareq_d  = 1'b1;
            wdog_d   = '0;
            streak_d = '0;
          end
        end
      end

      StWReq: begin
        if (I_fdma_wbusy) begin
          wareq_d = 1'b0;
          state_d = StWRun;
        end else if (wdog_q == WdogLast) begin
          wareq_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      StWRun: begin
        if (!I_fdma_wbusy) begin
          state_d = StIdle;
        end
      end

      StRReq: begin
        if (I_fdma_rbusy) begin
          rareq_d = 1'b0;
          state_d = StRRun;
        end else if (wdog_q == WdogLast) begin
          rareq_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      StRRun: begin
        if (!I_fdma_rbusy) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        wareq_d = 1'b0;
        rareq_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge I_fdma_clk) begin
    if (I_fdma_rst) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      wdog_q    <= '0;
      waddr_q   <= '0;
      wsize_q   <= '0;
      wareq_q   <= 1'b0;
      raddr_q   <= '0;
      rsize_q   <= '0;
      rareq_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wdog_q    <= wdog_d;
      waddr_q   <= waddr_d;
      wsize_q   <= wsize_d;
      wareq_q   <= wareq_d;
      raddr_q   <= raddr_d;
      rsize_q   <= rsize_d;
      rareq_q   <= rareq_d;
      timeout_q <= timeout_d;
    end
  end

  // Status from the FDMA is only forwarded to the stream that currently owns it.
  always_comb begin
    w_owned   = (state_q == StWReq) || (state_q == StWRun);
    r_owned   = (state_q == StRReq) || (state_q == StRRun);
    O_w_busy  = w_owned & I_fdma_wbusy;
    O_w_valid = w_owned & I_fdma_wvalid;
    O_r_busy  = r_owned & I_fdma_rbusy;
    O_r_valid = r_owned & I_fdma_rvalid;
  end

  assign O_fdma_waddr = waddr_q;
  assign O_fdma_wsize = wsize_q;
  assign O_fdma_wareq = wareq_q;
  assign O_fdma_raddr = raddr_q;
  assign O_fdma_rsize = rsize_q;
  assign O_fdma_rareq = rareq_q;
  assign O_timeout    = timeout_q;

  // Data paths are plain pass-through; qualification comes from the valid strobes.
  assign O_fdma_wdata = I_w_data;
  assign O_r_data     = I_fdma_rdata;

endmodule

// File: tb/tb_fdma_rw_arbiter.sv
// Bench for fdma_rw_arbiter: directed stimulus pushes expected grants into a queue, a
// monitor pops one per rising areq and compares port, address and size.
`timescale 1ns/1ps
module tb_fdma_rw_arbiter;

  localparam int unsigned ADDR_W        = 21;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MAX_RD_STREAK = 4;
  localparam int unsigned REQ_TIMEOUT   = 16;
  localparam int          BURST_CYC     = 3;

  localparam logic [ADDR_W-1:0] RA = 21'h100;
  localparam logic [15:0]       RS = 16'd512;
  localparam logic [ADDR_W-1:0] WA = 21'h2000;
  localparam logic [15:0]       WS = 16'd64;

  logic              clk;
  logic              rst;
  logic              sdr_busy;
  logic [ADDR_W-1:0] w_addr;
  logic              w_areq;
  logic [15:0]       w_size;
  logic [DATA_W-1:0] w_data;
  logic              o_w_busy, o_w_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_areq;
  logic [15:0]       r_size;
  logic [DATA_W-1:0] o_r_data;
  logic              o_r_busy, o_r_valid;
  logic [ADDR_W-1:0] fdma_waddr, fdma_raddr;
  logic              fdma_wareq, fdma_rareq;
  logic [15:0]       fdma_wsize, fdma_rsize;
  logic [DATA_W-1:0] fdma_wdata;
  logic              fdma_wbusy, fdma_wvalid;
  logic [DATA_W-1:0] fdma_rdata;
  logic              fdma_rbusy, fdma_rvalid;
  logic              o_timeout;

  fdma_rw_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_RD_STREAK (MAX_RD_STREAK),
    .REQ_TIMEOUT   (REQ_TIMEOUT)
  ) u_dut (
    .I_fdma_clk    (clk),
    .I_fdma_rst    (rst),
    .I_sdr_busy    (sdr_busy),
    .I_w_addr      (w_addr),
    .I_w_areq      (w_areq),
    .I_w_size      (w_size),
    .I_w_data      (w_data),
    .O_w_busy      (o_w_busy),
    .O_w_valid     (o_w_valid),
    .I_r_addr      (r_addr),
    .I_r_areq      (r_areq),
    .I_r_size      (r_size),
    .O_r_data      (o_r_data),
    .O_r_busy      (o_r_busy),
    .O_r_valid     (o_r_valid),
    .O_fdma_waddr  (fdma_waddr),
    .O_fdma_wareq  (fdma_wareq),
    .O_fdma_wsize  (fdma_wsize),
    .O_fdma_wdata  (fdma_wdata),
    .I_fdma_wbusy  (fdma_wbusy),
    .I_fdma_wvalid (fdma_wvalid),
    .O_fdma_raddr  (fdma_raddr),
    .O_fdma_rareq  (fdma_rareq),
    .O_fdma_rsize  (fdma_rsize),
    .I_fdma_rdata  (fdma_rdata),
    .I_fdma_rbusy  (fdma_rbusy),
    .I_fdma_rvalid (fdma_rvalid),
    .O_timeout     (o_timeout)
  );

  typedef struct packed {
    logic              is_w;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       size;
  } grant_t;

  grant_t exp_q[$];
  int     n_checks;
  int     n_fail;
  logic   resp_r_en;
  logic   resp_w_en;
  logic   prev_r, prev_w;
  grant_t mon_g, mon_e;
  int     rcnt, wcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_w);
    grant_t g;
    g.is_w = is_w;
    g.addr = is_w ? WA : RA;
    g.size = is_w ? WS : RS;
    exp_q.push_back(g);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: one expected grant per rising areq; areq lines must be mutually exclusive.
  initial begin
    prev_r = 1'b0;
    prev_w = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      check("areq_exclusive", {62'd0, fdma_wareq, fdma_rareq} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
      if ((fdma_rareq && !prev_r) || (fdma_wareq && !prev_w)) begin
        mon_g.is_w = fdma_wareq;
        mon_g.addr = fdma_wareq ? fdma_waddr : fdma_raddr;
        mon_g.size = fdma_wareq ? fdma_wsize : fdma_rsize;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_unexpected: got 0x%0h, expected none at %0t", mon_g, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant", 64'(mon_g), 64'(mon_e));
        end
      end
      prev_r = fdma_rareq;
      prev_w = fdma_wareq;
    end
  end

  // FDMA responder: answers an areq with BURST_CYC cycles of busy/valid.
  initial begin
    rcnt = 0;
    wcnt = 0;
    fdma_rbusy = 1'b0;
    fdma_rvalid = 1'b0;
    fdma_rdata = 32'hA500_0000;
    fdma_wbusy = 1'b0;
    fdma_wvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rcnt = 0;
        wcnt = 0;
        fdma_rbusy = 1'b0;
        fdma_rvalid = 1'b0;
        fdma_wbusy = 1'b0;
        fdma_wvalid = 1'b0;
      end else begin
        if (rcnt > 0) begin
          rcnt--;
          fdma_rbusy = (rcnt > 0);
          fdma_rvalid = (rcnt > 0);
          fdma_rdata = fdma_rdata + 32'd1;
        end else if (fdma_rareq && resp_r_en) begin
          rcnt = BURST_CYC;
          fdma_rbusy = 1'b1;
          fdma_rvalid = 1'b1;
        end
        if (wcnt > 0) begin
          wcnt--;
          fdma_wbusy = (wcnt > 0);
          fdma_wvalid = (wcnt > 0);
        end else if (fdma_wareq && resp_w_en) begin
          wcnt = BURST_CYC;
          fdma_wbusy = 1'b1;
          fdma_wvalid = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "time limit");
  end

  // Directed stimulus.
  initial begin
    int n;
    int cnt;
    n_checks  = 0;
    n_fail    = 0;
    resp_r_en = 1'b1;
    resp_w_en = 1'b1;
    rst       = 1'b1;
    sdr_busy  = 1'b0;
    w_addr    = WA;
    w_size    = WS;
    w_data    = 32'hDEAD_BEEF;
    r_addr    = RA;
    r_size    = RS;
    w_areq    = 1'b1;
    r_areq    = 1'b1;

    // Reset with both requesting, then streak ordering R,R,R,R,W twice.
    for (int i = 0; i < 2; i++) begin
      push(1'b0); push(1'b0); push(1'b0); push(1'b0); push(1'b1);
    end
    repeat (3) begin
      cyc();
      check("reset_ctl", {58'd0, fdma_wareq, fdma_rareq, o_timeout, o_w_busy, o_r_busy,
                          o_r_valid}, 64'd0);
      check("reset_addr", {22'd0, fdma_waddr, fdma_raddr}, 64'd0);
      check("reset_size", {32'd0, fdma_wsize, fdma_rsize}, 64'd0);
    end
    rst = 1'b0;
    cyc();
    check("areq_after_release", {62'd0, fdma_wareq, fdma_rareq}, 64'd1);
    wait_drain("streak_order", 300);
    w_areq = 1'b0;
    r_areq = 1'b0;
    repeat (15) cyc();

    // Read-only request.
    push(1'b0);
    r_areq = 1'b1;
    cyc();
    check("rd_req_t1", {26'd0, fdma_rareq, fdma_raddr, fdma_rsize}, {26'd0, 1'b1, RA, RS});
    cyc();
    check("rd_req_drop", {61'd0, fdma_rareq, o_r_busy, o_r_valid}, 64'd3);
    check("r_data_pass", 64'(o_r_data), 64'(fdma_rdata));
    check("w_data_pass", 64'(fdma_wdata), 64'h0000_0000_DEAD_BEEF);
    r_areq = 1'b0;
    repeat (3) cyc();
    check("rd_run_end", {62'd0, o_r_busy, o_r_valid}, 64'd0);
    repeat (5) cyc();
    check("rd_back_idle", {62'd0, fdma_wareq, fdma_rareq}, 64'd0);

    // SDRAM busy blocks grants; read first once it drops, then write.
    sdr_busy = 1'b1;
    w_areq = 1'b1;
    r_areq = 1'b1;
    repeat (10) begin
      cyc();
      check("sdr_busy_hold", {62'd0, fdma_wareq, fdma_rareq}, 64'd0);
    end
    push(1'b0);
    push(1'b1);
    sdr_busy = 1'b0;
    cyc();
    check("grant_after_sdr", {62'd0, fdma_wareq, fdma_rareq}, 64'd1);
    r_areq = 1'b0;
    wait_drain("sdr_drain", 100);
    w_areq = 1'b0;
    repeat (15) cyc();

    // Watchdog: write never acknowledged.
    resp_w_en = 1'b0;
    push(1'b1);
    w_areq = 1'b1;
    n = 0;
    while (!fdma_wareq && n < 10) begin
      cyc();
      n++;
    end
    r_areq = 1'b1;
    push(1'b0);
    cnt = 1;
    n = 0;
    while (n < 40) begin
      cyc();
      n++;
      if (fdma_wareq) cnt++;
      else break;
    end
    check("timeout_len", 64'(cnt), 64'(REQ_TIMEOUT));
    check("timeout_pulse", {62'd0, o_timeout, fdma_rareq}, 64'd2);
    w_areq = 1'b0;
    cyc();
    check("timeout_then_read", {62'd0, o_timeout, fdma_rareq}, 64'd1);
    r_areq = 1'b0;
    resp_w_en = 1'b1;
    wait_drain("timeout_drain", 50);
    repeat (15) cyc();

    // Reset during a read burst; streak must restart from zero.
    push(1'b0);
    r_areq = 1'b1;
    n = 0;
    while (!(o_r_busy && !fdma_rareq) && n < 20) begin
      cyc();
      n++;
    end
    check("reach_r_run", {62'd0, o_r_busy, fdma_rareq}, 64'd2);
    rst = 1'b1;
    w_areq = 1'b1;
    push(1'b0); push(1'b0); push(1'b0); push(1'b0); push(1'b1);
    cyc();
    check("rst_mid_burst", {61'd0, o_r_busy, fdma_rareq, fdma_wareq}, 64'd0);
    cyc();
    rst = 1'b0;
    wait_drain("streak_after_rst", 200);
    w_areq = 1'b0;
    r_areq = 1'b0;
    repeat (20) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
